// File: rtl/disaggregator_if.sv
// Handshake bundle between a show-ahead wide FIFO, the disaggregator and a narrow FIFO.
interface disaggregator_if #(
  parameter int DATA_WIDTH  = 11,
  parameter int FETCH_WIDTH = 4
);
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;
  logic                              receiver_last;

  modport master (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq, receiver_last
  );

  modport slave (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq, receiver_last
  );
endinterface

// File: rtl/disaggregator.sv
// Width-down converter: pops one wide word and emits its lanes LSB-first,
// refilling on the last lane so consecutive words stream without a bubble.
module disaggregator #(
  parameter int DATA_WIDTH  = 11,
  parameter int FETCH_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  disaggregator_if.master bus
);
  localparam int LANE_W = (FETCH_WIDTH > 2) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(FETCH_WIDTH - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                            state;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] hold;
  logic [LANE_W-1:0]                 lane;
  logic                              draining;
  logic                              refill;

  always_comb begin
    draining          = (state == DRAIN);
    bus.receiver_data = hold[DATA_WIDTH-1:0];
    bus.receiver_enq  = draining && bus.receiver_full_n;
    bus.receiver_last = draining && (lane == LAST_LANE);
    refill            = bus.receiver_enq && bus.receiver_last && bus.sender_empty_n;
    bus.sender_deq    = (!draining && bus.sender_empty_n) || refill;
  end

  // Load outranks shift so a refill on the last lane replaces the word in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      lane  <= '0;
    end else if (bus.sender_deq) begin
      state <= DRAIN;
      hold  <= bus.sender_data;
      lane  <= '0;
    end else if (bus.receiver_enq && !bus.receiver_last) begin
      hold  <= hold >> DATA_WIDTH;
      lane  <= lane + LANE_W'(1);
    end else if (bus.receiver_enq) begin
      state <= IDLE;
      hold  <= '0;
      lane  <= '0;
    end
  end
endmodule

// File: tb/tb_disaggregator.sv
// Random-stimulus bench: a lane-count model of the converter predicts every
// handshake and data value each cycle; phase logs pin the model to literals.
module tb_disaggregator;
  localparam int DW = 11;
  localparam int FW = 4;
  localparam int WW = DW * FW;

  typedef struct {
    logic [DW-1:0] d;
    int unsigned   idx;
  } lane_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disaggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus ();
  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  lane_t         pend[$];
  logic [WW-1:0] src[$];
  logic [DW-1:0] log_q[$];
  int unsigned   total = 0;
  int unsigned   bad = 0;
  int unsigned   deq_cnt = 0;
  int unsigned   full_pct = 100;
  bit            exp_enq, exp_deq, exp_last;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input int unsigned base);
    logic [WW-1:0] w;
    for (int i = 0; i < FW; i++) w[i*DW +: DW] = DW'(base + i);
    src.push_back(w);
  endtask

  // One clock: drive inputs after negedge, check, then advance the model at posedge.
  task automatic step();
    logic [WW-1:0] w;
    @(negedge clk);
    bus.receiver_full_n = ($urandom_range(99) < full_pct);
    bus.sender_empty_n  = (src.size() > 0);
    bus.sender_data     = (src.size() > 0) ? src[0] : WW'({$urandom(), $urandom()});
    #1;
    exp_enq  = !rst && pend.size() > 0 && bus.receiver_full_n;
    exp_last = !rst && pend.size() > 0 && pend[0].idx == FW - 1;
    exp_deq  = !rst && bus.sender_empty_n &&
               (pend.size() == 0 || (pend.size() == 1 && bus.receiver_full_n));
    chk("receiver_enq", 64'(bus.receiver_enq), 64'(exp_enq));
    chk("receiver_last", 64'(bus.receiver_last), 64'(exp_last));
    chk("sender_deq", 64'(bus.sender_deq), 64'(exp_deq));
    if (!rst && pend.size() > 0) chk("receiver_data", 64'(bus.receiver_data), 64'(pend[0].d));
    if (rst) chk("receiver_data_rst", 64'(bus.receiver_data), 64'(0));
    if (bus.receiver_enq) log_q.push_back(bus.receiver_data);
    if (bus.sender_deq) deq_cnt++;
    @(posedge clk);
    if (exp_enq) pend.delete(0);
    if (exp_deq) begin
      w = src.pop_front();
      for (int i = 0; i < FW; i++) pend.push_back('{d: w[i*DW +: DW], idx: i});
    end
  endtask

  task automatic run(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic check_log(input string nm, input int unsigned base, input int unsigned n);
    chk({nm, "_count"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk({nm, "_seq"}, 64'(log_q[i]), 64'(DW'(base + i)));
    log_q.delete();
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned c = 0;
    while ((src.size() > 0 || pend.size() > 0) && c < budget) begin
      step();
      c++;
    end
    chk("drain_timeout", 64'(src.size() + pend.size()), 64'(0));
  endtask

  initial begin
    int unsigned cnt;
    int unsigned c;
    rst = 1'b1;
    bus.sender_empty_n  = 1'b0;
    bus.receiver_full_n = 1'b1;
    bus.sender_data     = '0;
    #1;
    chk("rst_enq", 64'(bus.receiver_enq), 64'(0));
    chk("rst_deq", 64'(bus.sender_deq), 64'(0));
    chk("rst_last", 64'(bus.receiver_last), 64'(0));
    chk("rst_data", 64'(bus.receiver_data), 64'(0));
    run(2);
    #2 rst = 1'b0;

    // Single word: one pop, then four enqs 0..3 back to back.
    deq_cnt = 0;
    push_word(0);
    run(5);
    check_log("single", 0, 4);
    chk("single_deq_count", 64'(deq_cnt), 64'(1));
    run(2);

    // Back-to-back: 8 enqs in 9 cycles means no bubble at the word boundary.
    deq_cnt = 0;
    push_word(0);
    push_word(4);
    run(9);
    check_log("b2b", 0, 8);
    chk("b2b_deq_count", 64'(deq_cnt), 64'(2));
    run(2);

    // Backpressure on a 0..63 stream.
    full_pct = 50;
    for (int i = 0; i < 16; i++) push_word(i * FW);
    drain(400);
    check_log("stall", 0, 64);
    full_pct = 100;

    // Empty gap between two words.
    push_word(20);
    run(5);
    run(5);
    push_word(24);
    run(5);
    check_log("gap", 20, 8);

    // Reset in the middle of a word.
    push_word(0);
    c = 0;
    while (log_q.size() < 2 && c < 20) begin
      step();
      c++;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_enq", 64'(bus.receiver_enq), 64'(0));
    chk("mid_rst_last", 64'(bus.receiver_last), 64'(0));
    chk("mid_rst_data", 64'(bus.receiver_data), 64'(0));
    pend.delete();
    @(posedge clk);
    run(2);
    #2 rst = 1'b0;
    run(3);
    check_log("pre_rst", 0, 2);
    push_word(10);
    run(6);
    check_log("post_rst", 10, 4);

    // Long random run: random arrivals and random receiver stalls.
    full_pct = 70;
    cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (src.size() < 4 && $urandom_range(99) < 30) begin
        push_word(cnt);
        cnt += FW;
      end
      step();
    end
    drain(200);
    check_log("random", 0, cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
